// File: rtl/wifi_phy_pkg.sv
// Shared WiFi PHY RX definitions: rate codes, depuncturer states,
// puncturing masks and pattern periods.
package wifi_phy_pkg;

  localparam logic [1:0] RATE_1_2 = 2'b00;
  localparam logic [1:0] RATE_2_3 = 2'b01;
  localparam logic [1:0] RATE_3_4 = 2'b10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Bit i set means output slot i carries a received bit.
  localparam logic [3:0] PUNC_MASK_2_3 = 4'b0111;
  localparam logic [5:0] PUNC_MASK_3_4 = 6'b100111;

  localparam logic [2:0] PERIOD_1_2 = 3'd2;
  localparam logic [2:0] PERIOD_2_3 = 3'd4;
  localparam logic [2:0] PERIOD_3_4 = 3'd6;

  // The reserved code 11 behaves as an unpunctured rate-1/2 frame.
  function automatic logic [1:0] rate_norm(input logic [1:0] rate);
    return (rate == 2'b11) ? RATE_1_2 : rate;
  endfunction

endpackage

// File: rtl/depunct_pattern.sv
// Puncturing pattern decode: for the latched rate and current output slot,
// reports whether the slot carries data and whether it closes the period.
module depunct_pattern
  import wifi_phy_pkg::*;
(
  input  logic [1:0] rate_r,
  input  logic [2:0] slot,
  output logic       is_data,
  output logic       period_end
);

  logic [7:0] mask_3_4;

  assign mask_3_4 = {2'b00, PUNC_MASK_3_4};

  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves it unassigned (no latch).
    is_data    = 1'b1;
    period_end = (slot == PERIOD_1_2 - 3'd1);
    case (rate_r)
      RATE_2_3: begin
        is_data    = PUNC_MASK_2_3[slot[1:0]];
        period_end = (slot == PERIOD_2_3 - 3'd1);
      end
      RATE_3_4: begin
        is_data    = mask_3_4[slot];
        period_end = (slot == PERIOD_3_4 - 3'd1);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/wifi_depuncturer.sv
// WiFi RX depuncturer: re-inserts dummy bits for rates 2/3 and 3/4 and writes
// a rate-1/2 A/B stream into the decoder FIFO. Optional erasure flag output
// is enabled by defining DEPUNCT_ERASURE_EN.
module wifi_depuncturer
  import wifi_phy_pkg::*;
#(
  parameter int   LW        = 16,
  parameter logic DUMMY_BIT = 1'b0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [1:0]    rate,
  input  logic [LW-1:0] n_coded,
  input  logic          valid_in,
  input  logic          data_in,
  output logic          ready_in,
  input  logic          hold,
  output logic          we,
  output logic          data_out,
`ifdef DEPUNCT_ERASURE_EN
  output logic          erasure_out,
`endif
  output logic          busy,
  output logic          done
);

  state_t        state, state_d;
  logic [2:0]    slot, slot_d, slot_inc;
  logic [LW-1:0] count, count_d, count_inc;
  logic [LW-1:0] len_r, len_d;
  logic [1:0]    rate_r, rate_d;
  logic          we_d, dout_d;
  logic          is_data, period_end;

  depunct_pattern u_pattern (
    .rate_r     (rate_r),
    .slot       (slot),
    .is_data    (is_data),
    .period_end (period_end)
  );

  assign slot_inc  = period_end ? 3'd0 : slot + 3'd1;
  assign count_inc = count + LW'(1);

  always_comb begin
    state_d  = state;
    slot_d   = slot;
    count_d  = count;
    len_d    = len_r;
    rate_d   = rate_r;
    we_d     = 1'b0;
    dout_d   = DUMMY_BIT;
    ready_in = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          rate_d  = rate_norm(rate);
          len_d   = n_coded;
          slot_d  = 3'd0;
          count_d = '0;
          state_d = (n_coded == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (!hold) begin
          if (is_data) begin
            ready_in = 1'b1;
            if (valid_in) begin
              we_d    = 1'b1;
              dout_d  = data_in;
              count_d = count_inc;
              slot_d  = slot_inc;
              // A frame ending mid-period pads out the period to keep A/B pairs aligned.
              if (count_inc == len_r) state_d = period_end ? DONE : FLUSH;
            end
          end else begin
            we_d   = 1'b1;
            slot_d = slot_inc;
          end
        end
      end
      FLUSH: begin
        if (!hold) begin
          we_d   = 1'b1;
          slot_d = slot_inc;
          if (period_end) state_d = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      slot     <= 3'd0;
      count    <= '0;
      len_r    <= '0;
      rate_r   <= RATE_1_2;
      we       <= 1'b0;
      data_out <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state    <= state_d;
      slot     <= slot_d;
      count    <= count_d;
      len_r    <= len_d;
      rate_r   <= rate_d;
      we       <= we_d;
      data_out <= dout_d;
      busy     <= (state_d == RUN) || (state_d == FLUSH);
      done     <= (state == DONE);
    end
  end

`ifdef DEPUNCT_ERASURE_EN
  logic erase_d;

  assign erase_d = (state == FLUSH) || ((state == RUN) && !is_data);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) erasure_out <= 1'b0;
    else        erasure_out <= we_d & erase_d;
  end
`endif

endmodule

// File: tb/tb_wifi_depuncturer.sv
// Directed bench for wifi_depuncturer: hand-computed write streams for each
// rate, flow control, zero-length frames and mid-frame reset.
module tb_wifi_depuncturer;

  localparam int LW = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic [1:0]    rate = 2'b00;
  logic [LW-1:0] n_coded = '0;
  logic          valid_in = 1'b0;
  logic          data_in = 1'b0;
  logic          hold = 1'b0;
  logic          ready_in, we, data_out, busy, done;
`ifdef DEPUNCT_ERASURE_EN
  logic          erasure_out;
`endif

  wifi_depuncturer #(.LW(LW), .DUMMY_BIT(1'b0)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .rate        (rate),
    .n_coded     (n_coded),
    .valid_in    (valid_in),
    .data_in     (data_in),
    .ready_in    (ready_in),
    .hold        (hold),
    .we          (we),
    .data_out    (data_out),
`ifdef DEPUNCT_ERASURE_EN
    .erasure_out (erasure_out),
`endif
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Monitor state, sampled mid-cycle by step().
  int          cyc = 0;
  logic [31:0] wr_bits, er_bits;
  int          wr_cnt, done_cnt, done_cyc, last_we_cyc, rdy_hi, rdy_lo, hold_viol;
  logic        hold_last, acc;

  task automatic clear_mon();
    wr_bits = '0; er_bits = '0; wr_cnt = 0; done_cnt = 0; done_cyc = -1;
    last_we_cyc = -1; rdy_hi = 0; rdy_lo = 0; hold_viol = 0; hold_last = 1'b0;
  endtask

  // One clock: sample outputs at the falling edge, then return 1 time unit after the rising edge.
  task automatic step();
    @(negedge clk);
    if (we) begin
      wr_bits = {wr_bits[30:0], data_out};
`ifdef DEPUNCT_ERASURE_EN
      er_bits = {er_bits[30:0], erasure_out};
`endif
      wr_cnt++;
      last_we_cyc = cyc;
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (busy && !hold) begin
      if (ready_in) rdy_hi++;
      else          rdy_lo++;
    end
    if (we && hold_last) hold_viol++;
    hold_last = hold;
    acc = valid_in && ready_in;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  int start_cyc;

  // Bits are sent MSB first from bits[n-1].
  task automatic run_frame(input logic [1:0] r, input int n, input logic [15:0] bits,
                           input bit gaps, input int hold_from, input int hold_len,
                           input int restart_at, input string tag);
    int idx;
    int k;
    clear_mon();
    rate = r;
    n_coded = LW'(n);
    start = 1'b1;
    start_cyc = cyc;
    step();
    start = 1'b0;
    idx = 0;
    k = 0;
    while (idx < n && k < 200) begin
      valid_in = gaps ? (k % 2 == 0) : 1'b1;
      data_in  = bits[n-1-idx];
      hold     = (k >= hold_from) && (k < hold_from + hold_len);
      if (k == restart_at) begin
        start = 1'b1; rate = 2'b10; n_coded = LW'(2);
      end else begin
        start = 1'b0;
      end
      step();
      if (acc) idx++;
      k++;
    end
    valid_in = 1'b0; hold = 1'b0; start = 1'b0;
    if (n > 0) check({tag, "_fed"}, 32'(idx), 32'(n));
    k = 0;
    while (done_cnt == 0 && k < 50) begin
      step();
      k++;
    end
    repeat (3) step();
  endtask

  initial begin
    clear_mon();
    #2;
    check("rst_we",       32'(we),       32'h0);
    check("rst_data_out", 32'(data_out), 32'h0);
    check("rst_ready_in", 32'(ready_in), 32'h0);
    check("rst_busy",     32'(busy),     32'h0);
    check("rst_done",     32'(done),     32'h0);
    #10 reset = 1'b1;
    @(posedge clk); #1;

    // Rate 1/2: straight copy, done one cycle after the last write.
    run_frame(2'b00, 8, 16'h00B2, 1'b0, -1, 0, -1, "r12");
    check("r12_bits",     wr_bits,        32'hB2);
    check("r12_writes",   32'(wr_cnt),    32'd8);
    check("r12_done_lat", 32'(done_cyc),  32'(last_we_cyc + 1));
    check("r12_done_cnt", 32'(done_cnt),  32'd1);

    // Rate 3/4, all ones: DDDXXD DDDXXD.
    run_frame(2'b10, 8, 16'h00FF, 1'b0, -1, 0, -1, "r34");
    check("r34_bits",     wr_bits,        32'hE79);
    check("r34_writes",   32'(wr_cnt),    32'd12);
    check("r34_ready_hi", 32'(rdy_hi),    32'd8);
    check("r34_ready_lo", 32'(rdy_lo),    32'd4);
    check("r34_done_lat", 32'(done_cyc),  32'(last_we_cyc + 1));
`ifdef DEPUNCT_ERASURE_EN
    check("r34_erasure",  er_bits,        32'h186);
`endif

    // Rate 2/3, five ones: 1110 11 then two flush slots.
    run_frame(2'b01, 5, 16'h001F, 1'b0, -1, 0, -1, "r23");
    check("r23_bits",     wr_bits,        32'hEC);
    check("r23_writes",   32'(wr_cnt),    32'd8);
    check("r23_ready_hi", 32'(rdy_hi),    32'd5);
    check("r23_ready_lo", 32'(rdy_lo),    32'd3);
    check("r23_done_lat", 32'(done_cyc),  32'(last_we_cyc + 1));

    // Rate 3/4 mixed bits, gap-free and then with valid gaps plus a 3-cycle hold.
    run_frame(2'b10, 8, 16'h00B2, 1'b0, -1, 0, -1, "r34m");
    check("r34m_bits",    wr_bits,        32'hA48);
    check("r34m_writes",  32'(wr_cnt),    32'd12);
    run_frame(2'b10, 8, 16'h00B2, 1'b1, 4, 3, -1, "r34g");
    check("r34g_bits",    wr_bits,        32'hA48);
    check("r34g_writes",  32'(wr_cnt),    32'd12);
    check("r34g_hold_we", 32'(hold_viol), 32'd0);

    // Zero-length frame: done only, no writes.
    run_frame(2'b00, 0, 16'h0000, 1'b0, -1, 0, -1, "zero");
    check("zero_writes",   32'(wr_cnt),   32'd0);
    check("zero_done_lat", 32'(done_cyc), 32'(start_cyc + 2));

    // start pulse mid-frame must not disturb the running frame.
    run_frame(2'b00, 4, 16'h000D, 1'b0, -1, 0, 2, "busy");
    check("busy_bits",     wr_bits,       32'hD);
    check("busy_writes",   32'(wr_cnt),   32'd4);
    check("busy_done_cnt", 32'(done_cnt), 32'd1);

    // Reset after three writes of a 3/4 frame.
    clear_mon();
    rate = 2'b10; n_coded = LW'(8); start = 1'b1;
    step();
    start = 1'b0; valid_in = 1'b1; data_in = 1'b1;
    begin
      int k;
      k = 0;
      while (wr_cnt < 3 && k < 20) begin
        step();
        k++;
      end
    end
    check("mrst_reached", 32'(wr_cnt), 32'd3);
    reset = 1'b0;
    #1;
    check("mrst_we",       32'(we),       32'h0);
    check("mrst_data_out", 32'(data_out), 32'h0);
    check("mrst_busy",     32'(busy),     32'h0);
    check("mrst_ready_in", 32'(ready_in), 32'h0);
    check("mrst_done",     32'(done),     32'h0);
    valid_in = 1'b0;
    #2 reset = 1'b1;
    repeat (3) step();
    check("mrst_no_done",  32'(done_cnt), 32'd0);
    run_frame(2'b00, 2, 16'h0002, 1'b0, -1, 0, -1, "post");
    check("post_bits",     wr_bits,       32'h2);
    check("post_writes",   32'(wr_cnt),   32'd2);
    check("post_done_cnt", 32'(done_cnt), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
